final_blk: RTL and testbench
============================

FINAL_BLK -- requirements
Module: final_blk

Interface
REQ-001 Parameter ROT, default 1, meaning left-rotate amount applied to long_in; legal range 0..128.
REQ-002 Parameter ACC_EN, default 1, meaning 1 = x accumulates a, 0 = x registers a directly.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 a  input  64  accumulator operand.
REQ-006 long_in  input  129  wide data operand.
REQ-007 x  output  64  registered accumulator result.
REQ-008 long_out  output  129  registered rotated copy of long_in.

Function
REQ-009 When ACC_EN=1, x SHALL update each rising clk edge to x + a, modulo 2^64; carry out is discarded.
REQ-010 When ACC_EN=0, x SHALL update each rising clk edge to a.
REQ-011 long_out SHALL update each rising clk edge to long_in rotated left by ROT bits over 129 bits: bit i of the result = long_in[(i - ROT) mod 129].
REQ-012 ROT=0 SHALL make long_out a plain one-cycle-delayed copy of long_in.
REQ-013 Latency SHALL be exactly one clk cycle from input to x and to long_out; no handshake; a new input is accepted every cycle.
REQ-014 x wrap-around: 0xFFFF_FFFF_FFFF_FFFF + 1 SHALL yield 0, with no flag and no stall.
REQ-015 Outputs SHALL be driven only from flops; no combinational path from inputs to outputs.
REQ-016 Both outputs SHALL hold their value only between edges; there is no enable or hold mode.

Reset
REQ-017 rst_n low SHALL immediately, independent of clk, force x=0 and long_out=0.
REQ-018 While rst_n is low, outputs SHALL stay 0 regardless of a, long_in, or clk.
REQ-019 After rst_n deasserts, the first rising clk edge SHALL perform a normal update from the reset state: x=a with ACC_EN=1 or ACC_EN=0; long_out=rotl(long_in).
REQ-020 Reset asserted mid-operation SHALL discard the accumulated sum with no residual state.

Structure
REQ-021 A shared package final_pkg SHALL hold A_W=64, L_W=129, and the typedefs a_t (logic [A_W-1:0]) and long_t (logic [L_W-1:0]).
REQ-022 The rotation SHALL be a combinational sub-module rotl_129, parameterised by ROT; the accumulator and output registers SHALL live in final_blk.

Verification
REQ-023 Reset check: assert rst_n=0 between clk edges with nonzero state -> x=0 and long_out=0 immediately, before the next edge.
REQ-024 Accumulate: ACC_EN=1, after reset drive a=5, 7, 0x10 on three edges -> x reads 5, 12, 28 after each edge.
REQ-025 Wrap: x=0xFFFF_FFFF_FFFF_FFFF, a=2 -> x=1 after the next edge.
REQ-026 Rotate: ROT=1, long_in=1<<128 -> long_out=1 after one edge; long_in=1 -> long_out=2.
REQ-027 Passthrough: ROT=0, ACC_EN=0, a=0xDEAD_BEEF, long_in=all-ones -> x=0xDEAD_BEEF and long_out=all-ones one edge later.
REQ-028 Mid-run reset: accumulate to 100, pulse rst_n low for 3 ns, then a=1 -> x=1 after the first edge following release.

Source files
------------

// File: rtl/final_pkg.sv
// Shared widths and data types for the final_blk accumulator/rotator slice.
package final_pkg;
   localparam int A_W = 64;
   localparam int L_W = 129;

   typedef logic [A_W-1:0] a_t;
   typedef logic [L_W-1:0] long_t;
endpackage

// File: rtl/rotl_129.sv
// Fixed left-rotate of a 129-bit word by ROT bits; pure wiring, no state.
// Combinational only, so it adds no latency and has no flow control.
module rotl_129
   import final_pkg::*;
#(
   parameter int ROT = 1
) (
   input  logic [L_W-1:0] din,
   output logic [L_W-1:0] dout
);

   if (ROT < 0 || ROT > L_W - 1) begin : g_bad_rot
      $error("rotl_129: ROT out of range 0..128");
   end

   // Output bit i is sourced from input bit (i - ROT) mod L_W.
   for (genvar i = 0; i < L_W; i++) begin : g_bit
      assign dout[i] = din[(i + L_W - ROT) % L_W];
   end

endmodule

// File: rtl/final_blk.sv
// 64-bit accumulator (or plain register) plus a registered 129-bit left-rotate.
// Both outputs are flops with 1-cycle latency; no handshake, one input accepted every cycle.
module final_blk
   import final_pkg::*;
#(
   parameter int ROT    = 1,
   parameter bit ACC_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [A_W-1:0] a,
   input  logic [L_W-1:0] long_in,
   output logic [A_W-1:0] x,
   output logic [L_W-1:0] long_out
);

   long_t rot_dat;

   rotl_129 #(.ROT(ROT)) u_rotl (
      .din  (long_in),
      .dout (rot_dat)
   );

   // Sum wraps modulo 2^64; the carry is intentionally dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x        <= '0;
         long_out <= '0;
      end else begin
         x        <= ACC_EN ? (x + a) : a;
         long_out <= rot_dat;
      end
   end

endmodule

// File: tb/tb_final_blk.sv
// Self-checking bench for final_blk: directed table, corner sequences, randomized vs model.
module tb_final_blk;
   import final_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n;
   a_t    a;
   long_t li;
   a_t    x0, x1, x2;
   long_t lo0, lo1, lo2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   final_blk u0 (.clk(clk), .rst_n(rst_n), .a(a), .long_in(li), .x(x0), .long_out(lo0));
   final_blk #(.ROT(0), .ACC_EN(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .a(a), .long_in(li), .x(x1), .long_out(lo1));
   final_blk #(.ROT(77), .ACC_EN(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .a(a), .long_in(li), .x(x2), .long_out(lo2));

   typedef struct {
      a_t    a;
      long_t li;
      a_t    ex;
      long_t elo;
   } vec_t;

   vec_t tbl[4];

   function automatic long_t rotl(input long_t v, input int r);
      if (r == 0) return v;
      return (v << r) | (v >> (L_W - r));
   endfunction

   task automatic chk(input string nm, input logic [L_W-1:0] act, input logic [L_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic zeros(input string nm);
      chk({nm, " x0"}, long_t'(x0), '0);
      chk({nm, " lo0"}, lo0, '0);
      chk({nm, " x1"}, long_t'(x1), '0);
      chk({nm, " lo1"}, lo1, '0);
      chk({nm, " x2"}, long_t'(x2), '0);
      chk({nm, " lo2"}, lo2, '0);
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      a     = 64'h1234;
      li    = {1'b1, 128'hA5A5};
      cyc;
      cyc;
      zeros("rst_hold");
      rst_n = 1'b1;
   endtask

   a_t m0, m2;
   a_t ones64;
   long_t ones129;

   initial begin
      ones64  = '1;
      ones129 = '1;
      tbl[0] = '{a: 64'd5,  li: {1'b1, 128'd0}, ex: 64'd5,  elo: long_t'(1)};
      tbl[1] = '{a: 64'd7,  li: long_t'(1),     ex: 64'd12, elo: long_t'(2)};
      tbl[2] = '{a: 64'h10, li: ones129,        ex: 64'd28, elo: ones129};
      tbl[3] = '{a: 64'd0,  li: long_t'(3),     ex: 64'd28, elo: long_t'(6)};

      rst_n = 1'b0;
      a     = '0;
      li    = '0;
      #2;
      zeros("rst_init");
      do_reset;

      // Directed accumulate/rotate table on the default instance.
      for (int i = 0; i < 4; i++) begin
         a  = tbl[i].a;
         li = tbl[i].li;
         cyc;
         chk($sformatf("tbl%0d x", i), long_t'(x0), long_t'(tbl[i].ex));
         chk($sformatf("tbl%0d lo", i), lo0, tbl[i].elo);
      end

      // Asynchronous reset between edges with nonzero state.
      #2;
      rst_n = 1'b0;
      #1;
      zeros("async_rst");
      do_reset;

      // Wrap-around sequence.
      a = ones64;  cyc; chk("wrap_a x", long_t'(x0), long_t'(ones64));
      a = 64'd1;   cyc; chk("wrap_b x", long_t'(x0), '0);
      a = ones64;  cyc; chk("wrap_c x", long_t'(x0), long_t'(ones64));
      a = 64'd2;   cyc; chk("wrap_d x", long_t'(x0), long_t'(1));

      // Passthrough instance.
      a  = 64'hDEAD_BEEF;
      li = ones129;
      cyc;
      chk("pass x", long_t'(x1), long_t'(64'hDEAD_BEEF));
      chk("pass lo", lo1, ones129);

      // Mid-run reset: accumulate to 100, short low pulse, then a=1.
      do_reset;
      a = 64'd50; cyc;
      a = 64'd50; cyc;
      chk("mid acc100", long_t'(x0), long_t'(100));
      #2;
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      a = 64'd1;
      cyc;
      chk("mid x0", long_t'(x0), long_t'(1));
      chk("mid x1", long_t'(x1), long_t'(1));
      chk("mid x2", long_t'(x2), long_t'(1));

      // Randomized run against the reference model, with occasional async resets.
      do_reset;
      m0 = '0;
      m2 = '0;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(39) == 0) begin
            rst_n = 1'b0;
            #2;
            zeros("rnd_rst");
            rst_n = 1'b1;
            m0 = '0;
            m2 = '0;
         end
         a  = {$urandom(), $urandom()};
         li = {1'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
         cyc;
         m0 = m0 + a;
         m2 = m2 + a;
         chk("rnd x0", long_t'(x0), long_t'(m0));
         chk("rnd lo0", lo0, rotl(li, 1));
         chk("rnd x1", long_t'(x1), long_t'(a));
         chk("rnd lo1", lo1, li);
         chk("rnd x2", long_t'(x2), long_t'(m2));
         chk("rnd lo2", lo2, rotl(li, 77));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
